// File: rtl/span_pkg.sv
// Shared types and sizing helpers for the span walker and its step divider.
package span_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, DIV, WALK, FIN} state_t;

   localparam int ATTR_W_DEF = 16;
   localparam int FRAC_W_DEF = 8;
   localparam int ACC_W      = ATTR_W_DEF + FRAC_W_DEF + 1;

   function automatic int acc_width(input int attr_w, input int frac_w);
      return attr_w + frac_w + 1;
   endfunction

   // One quotient bit per cycle over the full signed accumulator width.
   function automatic int div_lat(input int attr_w, input int frac_w);
      return acc_width(attr_w, frac_w);
   endfunction

endpackage

// File: rtl/span_if.sv
// Span request / pixel output bundle between edge setup, span_interp and the pixel stage.
interface span_if #(
   parameter int COORD_W  = 11,
   parameter int ATTR_W   = 16,
   parameter int NUM_ATTR = 2
);
   logic                               start;
   logic [COORD_W-1:0]                 x0;
   logic [COORD_W-1:0]                 x1;
   logic [COORD_W-1:0]                 y;
   logic [NUM_ATTR-1:0][ATTR_W-1:0]    attr_a;
   logic [NUM_ATTR-1:0][ATTR_W-1:0]    attr_b;
   logic                               busy;
   logic                               plot;
   logic                               plot_ready;
   logic [COORD_W-1:0]                 x_out;
   logic [COORD_W-1:0]                 y_out;
   logic [NUM_ATTR-1:0][ATTR_W-1:0]    attr_out;
   logic                               done;

   modport master (
      output start, x0, x1, y, attr_a, attr_b, plot_ready,
      input  busy, plot, x_out, y_out, attr_out, done
   );

   modport slave (
      input  start, x0, x1, y, attr_a, attr_b, plot_ready,
      output busy, plot, x_out, y_out, attr_out, done
   );
endinterface

// File: rtl/span_step_div.sv
// Signed restoring divider: quot = num / den truncated toward zero, NUM_W cycles after start.
module span_step_div import span_pkg::*; #(
   parameter int NUM_W = ACC_W,
   parameter int DEN_W = 11
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [NUM_W-1:0] num,
   input  logic [DEN_W-1:0]        den,
   output logic                    done,
   output logic signed [NUM_W-1:0] quot
);
   localparam int CNT_W = $clog2(NUM_W);

   logic             active;
   logic [CNT_W-1:0] cnt;
   logic [NUM_W-1:0] q, q_nx;
   logic [DEN_W-1:0] rem, rem_nx, d_r;
   logic [DEN_W:0]   shifted;
   logic             neg;

   always_comb begin
      shifted = {rem, q[NUM_W-1]};
      if (shifted >= {1'b0, d_r}) begin
         rem_nx = DEN_W'(shifted - {1'b0, d_r});
         q_nx   = {q[NUM_W-2:0], 1'b1};
      end else begin
         rem_nx = shifted[DEN_W-1:0];
         q_nx   = {q[NUM_W-2:0], 1'b0};
      end
   end

   // The final quotient is exposed combinationally during the last iteration so the
   // caller can capture it and restart the divider on the same edge.
   assign done = active && (cnt == '0);
   assign quot = neg ? -q_nx : q_nx;

   always_ff @(posedge clk) begin
      if (!reset) begin
         active <= 1'b0;
         cnt    <= '0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= CNT_W'(NUM_W - 1);
      end else if (active) begin
         if (cnt == '0) active <= 1'b0;
         else           cnt    <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         q   <= num[NUM_W-1] ? -num : num;
         neg <= num[NUM_W-1];
         rem <= '0;
         d_r <= den;
      end else if (active) begin
         q   <= q_nx;
         rem <= rem_nx;
      end
   end

endmodule

// File: rtl/span_interp.sv
// Scanline span walker: per-attribute fixed-point steps from one shared divider, one pixel per cycle.
// Optional feature macro SPAN_CLIP_EN suppresses pixels beyond column X_MAX.
module span_interp import span_pkg::*; #(
   parameter int COORD_W  = 11,
   parameter int ATTR_W   = 16,
   parameter int NUM_ATTR = 2,
   parameter int FRAC_W   = 8,
   parameter int X_MAX    = 639
) (
   input logic  clk,
   input logic  reset,
   span_if.slave bus
);
   localparam int ACC_BITS = acc_width(ATTR_W, FRAC_W);
   localparam int CH_W     = (NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_ATTR - 1);
   localparam logic signed [ACC_BITS-1:0] ATTR_MAX = ACC_BITS'((1 << ATTR_W) - 1);

   typedef logic [NUM_ATTR-1:0][ATTR_W-1:0] attr_vec_t;

   state_t                     state, state_nx;
   logic [COORD_W-1:0]         x0_r, x1_r, y_r, x_cur;
   attr_vec_t                  a_r, b_r;
   logic [CH_W-1:0]            ch, div_ch;
   logic signed [ACC_BITS-1:0] acc  [NUM_ATTR];
   logic signed [ACC_BITS-1:0] step [NUM_ATTR];

   logic                       swap, clip_all, past_max, last_px, hs, plot_i;
   logic [COORD_W-1:0]         x_lo, x_hi, dx;
   attr_vec_t                  a_s, b_s, attr_o;
   logic                       div_start, div_done;
   logic signed [ACC_BITS-1:0] div_num, div_quot;

   function automatic logic signed [ACC_BITS-1:0] scaled_diff(input logic [ATTR_W-1:0] a,
                                                              input logic [ATTR_W-1:0] b);
      logic signed [ATTR_W:0] diff;
      diff = $signed({1'b0, b}) - $signed({1'b0, a});
      return {diff, {FRAC_W{1'b0}}};
   endfunction

   function automatic logic [ATTR_W-1:0] sat_attr(input logic signed [ACC_BITS-1:0] v);
      logic signed [ACC_BITS-1:0] ip;
      ip = v >>> FRAC_W;
      if (ip[ACC_BITS-1])     return '0;
      else if (ip > ATTR_MAX) return '1;
      else                    return ip[ATTR_W-1:0];
   endfunction

   // Raw request registers stay untouched for the whole span; ordering is resolved here.
   always_comb begin
      swap = (x1_r < x0_r);
      x_lo = swap ? x1_r : x0_r;
      x_hi = swap ? x0_r : x1_r;
      a_s  = swap ? b_r : a_r;
      b_s  = swap ? a_r : b_r;
      dx   = x_hi - x_lo;
   end

`ifdef SPAN_CLIP_EN
   assign clip_all = (x_lo  > COORD_W'(X_MAX));
   assign past_max = (x_cur > COORD_W'(X_MAX));
`else
   assign clip_all = 1'b0;
   assign past_max = 1'b0;
`endif

   assign last_px   = (x_cur == x_hi);
   assign plot_i    = (state == WALK) && !past_max;
   assign hs        = plot_i && bus.plot_ready;
   assign div_ch    = (state == SETUP) ? '0 : ch + 1'b1;
   assign div_num   = scaled_diff(a_s[div_ch], b_s[div_ch]);
   assign div_start = ((state == SETUP) && !clip_all && (dx != '0)) ||
                      ((state == DIV) && div_done && (ch != LAST_CH));

   span_step_div #(.NUM_W(ACC_BITS), .DEN_W(COORD_W)) u_div (
      .clk   (clk),
      .reset (reset),
      .start (div_start),
      .num   (div_num),
      .den   (dx),
      .done  (div_done),
      .quot  (div_quot)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = SETUP;
         SETUP:   state_nx = clip_all ? FIN : DIV;
         DIV:     if ((dx == '0) || (div_done && (ch == LAST_CH))) state_nx = WALK;
         WALK:    if (past_max || (hs && last_px)) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are gated by plot so they read zero whenever no pixel is presented.
   always_comb begin
      attr_o = '0;
      if (plot_i) begin
         for (int i = 0; i < NUM_ATTR; i++)
            attr_o[i] = last_px ? b_s[i] : sat_attr(acc[i]);
      end
   end

   assign bus.busy     = (state == SETUP) || (state == DIV) || (state == WALK);
   assign bus.done     = (state == FIN);
   assign bus.plot     = plot_i;
   assign bus.x_out    = plot_i ? x_cur : '0;
   assign bus.y_out    = plot_i ? y_r   : '0;
   assign bus.attr_out = attr_o;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         ch    <= '0;
      end else begin
         state <= state_nx;
         if (state == SETUP)
            ch <= '0;
         else if ((state == DIV) && div_done && (ch != LAST_CH))
            ch <= ch + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if ((state == IDLE) && bus.start) begin
         x0_r <= bus.x0;
         x1_r <= bus.x1;
         y_r  <= bus.y;
         a_r  <= bus.attr_a;
         b_r  <= bus.attr_b;
      end
      if (state == SETUP) begin
         x_cur <= x_lo;
         for (int i = 0; i < NUM_ATTR; i++) begin
            acc[i]  <= $signed({1'b0, a_s[i], {FRAC_W{1'b0}}});
            step[i] <= '0;
         end
      end
      if ((state == DIV) && div_done)
         step[ch] <= div_quot;
      if (hs && !last_px) begin
         x_cur <= x_cur + 1'b1;
         for (int i = 0; i < NUM_ATTR; i++)
            acc[i] <= acc[i] + step[i];
      end
   end

endmodule

// File: tb/tb_span_interp.sv
// Directed self-checking bench for span_interp (clip cases follow SPAN_CLIP_EN).
`timescale 1ns/1ps
module tb_span_interp;
   localparam int COORD_W  = 11;
   localparam int ATTR_W   = 16;
   localparam int NUM_ATTR = 2;
   localparam int FRAC_W   = 8;
   localparam int DIV_LAT  = ATTR_W + FRAC_W + 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   t0;
   int   px_x[$], px_y[$], px_a0[$], px_a1[$], px_cyc[$], px_rdy[$];
   int   done_cyc, done_cnt, busy_at_done;
   bit   timed_out;

   span_if #(.COORD_W(COORD_W), .ATTR_W(ATTR_W), .NUM_ATTR(NUM_ATTR)) bus ();

   span_interp #(.COORD_W(COORD_W), .ATTR_W(ATTR_W), .NUM_ATTR(NUM_ATTR),
                 .FRAC_W(FRAC_W), .X_MAX(639)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic launch(input int x0, input int x1, input int y,
                         input int a0, input int a1, input int b0, input int b1);
      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.x0        = COORD_W'(x0);
      bus.x1        = COORD_W'(x1);
      bus.y         = COORD_W'(y);
      bus.attr_a[0] = ATTR_W'(a0);
      bus.attr_a[1] = ATTR_W'(a1);
      bus.attr_b[0] = ATTR_W'(b0);
      bus.attr_b[1] = ATTR_W'(b1);
      t0 = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Records every presented pixel until done; ready drops for stall_len plot cycles after stall_at handshakes.
   task automatic collect(input int stall_at, input int stall_len, input int budget);
      int hs = 0;
      int stalled = 0;
      px_x.delete(); px_y.delete(); px_a0.delete(); px_a1.delete(); px_cyc.delete(); px_rdy.delete();
      done_cyc = -1; done_cnt = 0; busy_at_done = -1; timed_out = 1'b1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         bus.plot_ready = !(hs == stall_at && stalled < stall_len);
         #1;
         if (bus.plot) begin
            px_x.push_back(int'(bus.x_out));
            px_y.push_back(int'(bus.y_out));
            px_a0.push_back(int'(bus.attr_out[0]));
            px_a1.push_back(int'(bus.attr_out[1]));
            px_cyc.push_back(cyc);
            px_rdy.push_back(int'(bus.plot_ready));
            if (bus.plot_ready) hs++;
            else stalled++;
         end
         if (bus.done) begin
            done_cyc = cyc; done_cnt++; busy_at_done = int'(bus.busy); timed_out = 1'b0;
            break;
         end
      end
      bus.plot_ready = 1'b1;
      @(negedge clk); #1;
      if (bus.done) done_cnt++;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         checks++;
         if ({bus.plot, bus.done, bus.busy} !== 3'b000 || bus.x_out !== '0 ||
             bus.y_out !== '0 || bus.attr_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: plot=%0b done=%0b busy=%0b x=%0d y=%0d attr=%h, required all zero",
                     bus.plot, bus.done, bus.busy, bus.x_out, bus.y_out, bus.attr_out);
         end
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic();
      int exp_a0[4] = '{0, 100, 200, 300};
      launch(10, 13, 5, 0, 100, 300, 100);
      collect(-1, 0, 200);
      checks++;
      if (timed_out || px_x.size() != 4) begin
         errors++;
         $display("FAIL basic_count: got %0d pixels (timeout=%0b), required 4", px_x.size(), timed_out);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (px_x[i] != 10 + i || px_y[i] != 5 || px_a0[i] != exp_a0[i] || px_a1[i] != 100) begin
               errors++;
               $display("FAIL basic_px%0d: got (%0d,%0d,%0d,%0d), required (%0d,5,%0d,100)",
                        i, px_x[i], px_y[i], px_a0[i], px_a1[i], 10 + i, exp_a0[i]);
            end
         end
         checks++;
         if (px_cyc[0] - t0 != 2 + NUM_ATTR * DIV_LAT) begin
            errors++;
            $display("FAIL basic_latency: first plot at cycle %0d, required %0d",
                     px_cyc[0] - t0, 2 + NUM_ATTR * DIV_LAT);
         end
         checks++;
         if (done_cyc != px_cyc[3] + 1 || done_cnt != 1 || busy_at_done != 0) begin
            errors++;
            $display("FAIL basic_done: done at %0d count %0d busy %0d, required %0d count 1 busy 0",
                     done_cyc, done_cnt, busy_at_done, px_cyc[3] + 1);
         end
      end
   endtask

   task automatic test_reversed();
      int exp_a0[4] = '{10, 20, 30, 40};
      launch(20, 17, 9, 40, 0, 10, 0);
      collect(-1, 0, 200);
      checks++;
      if (timed_out || px_x.size() != 4) begin
         errors++;
         $display("FAIL rev_count: got %0d pixels (timeout=%0b), required 4", px_x.size(), timed_out);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (px_x[i] != 17 + i || px_y[i] != 9 || px_a0[i] != exp_a0[i] || px_a1[i] != 0) begin
               errors++;
               $display("FAIL rev_px%0d: got (%0d,%0d,%0d,%0d), required (%0d,9,%0d,0)",
                        i, px_x[i], px_y[i], px_a0[i], px_a1[i], 17 + i, exp_a0[i]);
            end
         end
      end
   endtask

   task automatic test_single();
      launch(7, 7, 3, 55, 9, 55, 9);
      collect(-1, 0, 50);
      checks++;
      if (timed_out || px_x.size() != 1) begin
         errors++;
         $display("FAIL single_count: got %0d pixels (timeout=%0b), required 1", px_x.size(), timed_out);
      end else begin
         checks++;
         if (px_x[0] != 7 || px_y[0] != 3 || px_a0[0] != 55 || px_a1[0] != 9) begin
            errors++;
            $display("FAIL single_px: got (%0d,%0d,%0d,%0d), required (7,3,55,9)",
                     px_x[0], px_y[0], px_a0[0], px_a1[0]);
         end
         checks++;
         if (px_cyc[0] - t0 != 3 || done_cyc - t0 != 4 || done_cnt != 1) begin
            errors++;
            $display("FAIL single_timing: plot at %0d done at %0d count %0d, required 3, 4, 1",
                     px_cyc[0] - t0, done_cyc - t0, done_cnt);
         end
      end
   endtask

   task automatic test_stall();
      int acc_i = 0;
      launch(0, 7, 2, 0, 70, 700, 0);
      collect(3, 3, 300);
      checks++;
      if (timed_out || px_x.size() != 11) begin
         errors++;
         $display("FAIL stall_count: got %0d samples (timeout=%0b), required 11", px_x.size(), timed_out);
      end else begin
         for (int i = 0; i < 11; i++) begin
            checks++;
            if (px_x[i] != acc_i || px_a0[i] != 100 * acc_i || px_a1[i] != 70 - 10 * acc_i) begin
               errors++;
               $display("FAIL stall_s%0d: got (%0d,%0d,%0d), required (%0d,%0d,%0d)", i,
                        px_x[i], px_a0[i], px_a1[i], acc_i, 100 * acc_i, 70 - 10 * acc_i);
            end
            if (px_rdy[i] != 0) acc_i++;
         end
         checks++;
         if (acc_i != 8 || done_cyc != px_cyc[10] + 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL stall_done: handshakes %0d done at %0d count %0d, required 8, %0d, 1",
                     acc_i, done_cyc, done_cnt, px_cyc[10] + 1);
         end
      end
   endtask

   task automatic test_nondiv();
      int e3a[3] = '{0, 50, 100};
      int e4a[4] = '{0, 3, 6, 10};
      int e4b[4] = '{10, 6, 3, 0};
      launch(0, 2, 1, 0, 0, 100, 0);
      collect(-1, 0, 200);
      checks++;
      if (px_x.size() != 3) begin
         errors++;
         $display("FAIL nondiv3_count: got %0d pixels, required 3", px_x.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (px_x[i] != i || px_a0[i] != e3a[i]) begin
               errors++;
               $display("FAIL nondiv3_px%0d: got x=%0d depth=%0d, required x=%0d depth=%0d",
                        i, px_x[i], px_a0[i], i, e3a[i]);
            end
         end
      end
      launch(0, 3, 1, 0, 10, 10, 0);
      collect(-1, 0, 200);
      checks++;
      if (px_x.size() != 4) begin
         errors++;
         $display("FAIL nondiv4_count: got %0d pixels, required 4", px_x.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (px_x[i] != i || px_a0[i] != e4a[i] || px_a1[i] != e4b[i]) begin
               errors++;
               $display("FAIL nondiv4_px%0d: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                        i, px_x[i], px_a0[i], px_a1[i], i, e4a[i], e4b[i]);
            end
         end
      end
   endtask

   task automatic test_reset_abort();
      int hs = 0;
      int seen_done = 0;
      bit reached = 1'b0;
      launch(30, 37, 4, 0, 0, 700, 0);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk); #1;
         if (bus.done) seen_done++;
         if (bus.plot) hs++;
         if (hs == 2) begin reached = 1'b1; break; end
      end
      checks++;
      if (!reached) begin
         errors++;
         $display("FAIL abort_reach_walk: got %0d pixels before budget, required 2", hs);
      end
      reset = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      checks++;
      if (bus.plot !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_reset: plot=%0b busy=%0b, required 0 0", bus.plot, bus.busy);
      end
      reset = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         if (bus.done || bus.plot) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d done/plot cycles after abort, required 0", seen_done);
      end
      launch(40, 42, 6, 3, 0, 9, 6);
      collect(-1, 0, 200);
      checks++;
      if (px_x.size() != 3 || done_cnt != 1 ||
          px_a0[0] != 3 || px_a0[1] != 6 || px_a0[2] != 9 ||
          px_a1[0] != 0 || px_a1[1] != 3 || px_a1[2] != 6 || px_x[0] != 40 || px_x[2] != 42) begin
         errors++;
         $display("FAIL abort_new_span: got %0d pixels, done count %0d, required 3 pixels 3/6/9 0/3/6 at 40..42, done 1",
                  px_x.size(), done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int dc = -1;
      int pc = -1;
      int px = -1;
      launch(5, 5, 0, 1, 1, 1, 1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); #1;
         if (bus.done) begin dc = cyc; break; end
      end
      bus.start = 1'b1;
      bus.x0 = COORD_W'(9); bus.x1 = COORD_W'(9);
      bus.attr_a[0] = ATTR_W'(4); bus.attr_b[0] = ATTR_W'(4);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); #1;
         if (bus.plot) begin pc = cyc; px = int'(bus.x_out); break; end
      end
      checks++;
      if (dc < 0 || pc != dc + 4 || px != 9) begin
         errors++;
         $display("FAIL back_to_back: done at %0d, next plot at %0d x=%0d, required plot at %0d x=9",
                  dc, pc, px, dc + 4);
      end
      collect(-1, 0, 20);
   endtask

   task automatic test_clip();
      launch(637, 642, 8, 0, 0, 500, 0);
      collect(-1, 0, 200);
`ifdef SPAN_CLIP_EN
      checks++;
      if (timed_out || px_x.size() != 3 || px_x[0] != 637 || px_x[2] != 639 ||
          px_a0[0] != 0 || px_a0[2] != 200 || done_cnt != 1) begin
         errors++;
         $display("FAIL clip_span: got %0d pixels (timeout=%0b) done count %0d, required 637..639 depth 0..200, done 1",
                  px_x.size(), timed_out, done_cnt);
      end
`else
      checks++;
      if (timed_out || px_x.size() != 6 || px_x[0] != 637 || px_x[5] != 642 ||
          px_a0[3] != 300 || px_a0[5] != 500 || done_cnt != 1) begin
         errors++;
         $display("FAIL noclip_span: got %0d pixels (timeout=%0b) done count %0d, required 637..642 depth 0..500, done 1",
                  px_x.size(), timed_out, done_cnt);
      end
`endif
   endtask

   initial begin
      bus.start = 1'b0;
      bus.x0 = '0; bus.x1 = '0; bus.y = '0;
      bus.attr_a = '0; bus.attr_b = '0;
      bus.plot_ready = 1'b1;
      test_reset();
      test_basic();
      test_reversed();
      test_single();
      test_stall();
      test_nondiv();
      test_reset_abort();
      test_back_to_back();
      test_clip();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
